// File: rtl/leg_pkg.sv
// Shared types and default sizing for the LEG register-bank front-end.
package leg_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

    localparam int unsigned LEG_NREGS    = 6;
    localparam int unsigned LEG_AW       = 3;
    localparam int unsigned LEG_DW       = 8;
    localparam int unsigned LEG_MAX_WAIT = 4;

endpackage : leg_pkg

// File: rtl/leg_onehot_dec.sv
// Register index to one-hot strobe decoder with enable and out-of-range flag.
module leg_onehot_dec
    import leg_pkg::*;
#(
    parameter int unsigned AW    = LEG_AW,
    parameter int unsigned NREGS = LEG_NREGS
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [NREGS-1:0] onehot,
    output logic             oor
);

    // One strobe per implemented register; unimplemented indices raise oor instead.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (en && (addr == AW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
        oor = en && (32'(addr) >= NREGS);
    end

endmodule : leg_onehot_dec

// File: rtl/leg_regfile_arbiter.sv
// LEG register bank front-end: operand read decode plus core/debug write
// arbitration with a starvation counter that forces a debug slot.
module leg_regfile_arbiter
    import leg_pkg::*;
#(
    parameter int unsigned NREGS    = LEG_NREGS,
    parameter int unsigned AW       = LEG_AW,
    parameter int unsigned DW       = LEG_DW,
    parameter int unsigned MAX_WAIT = LEG_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_a_en,
    input  logic [AW-1:0]    rd_a_addr,
    input  logic             rd_b_en,
    input  logic [AW-1:0]    rd_b_addr,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic [DW-1:0]    wb_data,
    output logic             wb_ready,
    input  logic             dbg_valid,
    input  logic [AW-1:0]    dbg_addr,
    input  logic [DW-1:0]    dbg_data,
    output logic             dbg_ready,
    output logic [NREGS-1:0] reg_rd_a,
    output logic [NREGS-1:0] reg_rd_b,
    output logic [NREGS-1:0] reg_wr,
    output logic [DW-1:0]    reg_wdata,
    output logic             core_stall,
    output logic             addr_err
);

    localparam int unsigned      WCW  = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]   WMAX = WCW'(MAX_WAIT);

    arb_state_e     state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           addr_err_q, addr_err_d;

    logic           wb_grant, dbg_grant, stall;
    logic           wr_en, wr_oor;
    logic [AW-1:0]  wr_addr;
    logic           rd_a_oor, rd_b_oor;

    // Grant selection: FORCE belongs to debug; otherwise core has priority.
    // Everything is held off while reset is asserted.
    always_comb begin
        wb_grant  = 1'b0;
        dbg_grant = 1'b0;
        stall     = 1'b0;
        if (rst) begin
            if (state_q == FORCE) begin
                dbg_grant = dbg_valid;
                stall     = 1'b1;
            end else if (wb_valid) begin
                wb_grant  = 1'b1;
            end else if (dbg_valid) begin
                dbg_grant = 1'b1;
            end
            if (wb_valid && !wb_grant) begin
                stall = 1'b1;
            end
        end
    end

    // Winner's index/data; the write bus keeps its last value when idle.
    always_comb begin
        wr_en   = wb_grant || dbg_grant;
        wr_addr = wb_grant ? wb_addr : dbg_addr;
        if (wb_grant) begin
            wdata_d = wb_data;
        end else if (dbg_grant) begin
            wdata_d = dbg_data;
        end else begin
            wdata_d = wdata_q;
        end
        addr_err_d = addr_err_q || wr_oor;
    end

    // Starvation tracking: count debug losses, force a debug slot at the limit.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ARB: begin
                if (dbg_valid && !dbg_grant) begin
                    if (wait_cnt_q != WMAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_d == WMAX) begin
                        state_d = FORCE;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            FORCE: begin
                state_d    = ARB;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ARB;
                wait_cnt_d = '0;
            end
        endcase
    end

    // State, counter, write-bus hold and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB;
            wait_cnt_q <= '0;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    leg_onehot_dec #(.AW(AW), .NREGS(NREGS)) u_dec_rd_a (
        .en     (rd_a_en && rst),
        .addr   (rd_a_addr),
        .onehot (reg_rd_a),
        .oor    (rd_a_oor)
    );

    leg_onehot_dec #(.AW(AW), .NREGS(NREGS)) u_dec_rd_b (
        .en     (rd_b_en && rst),
        .addr   (rd_b_addr),
        .onehot (reg_rd_b),
        .oor    (rd_b_oor)
    );

    leg_onehot_dec #(.AW(AW), .NREGS(NREGS)) u_dec_wr (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (reg_wr),
        .oor    (wr_oor)
    );

    logic unused_rd_oor;
    assign unused_rd_oor = rd_a_oor ^ rd_b_oor;

    assign wb_ready   = wb_grant;
    assign dbg_ready  = dbg_grant;
    assign core_stall = stall;
    assign reg_wdata  = wdata_d;
    assign addr_err   = addr_err_q;

endmodule : leg_regfile_arbiter
